// File: rtl/cmd_sender_pkg.sv
// cmd_sender_pkg: shared state encoding and frame constants for the command sender
package cmd_sender_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} snd_state_t;
  localparam int FRAME_BITS = 10;
  localparam int BAUD_DIV_9600_50M = 5208;
endpackage

// File: rtl/cmd_sender_if.sv
// cmd_sender_if: command request/response bundle between a host and cmd_sender
interface cmd_sender_if;
  logic [15:0] cmd;
  logic snd_cmd;
  logic TX;
  logic busy;
  logic cmd_snt;
  modport master (output cmd, snd_cmd, input TX, busy, cmd_snt);
  modport slave (input cmd, snd_cmd, output TX, busy, cmd_snt);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with registered TX; a load during tx_done chains frames gaplessly
module uart_tx_byte
  import cmd_sender_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_9600_50M,
  parameter int CNT_W = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done
);
  logic busy_q, busy_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [8:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic wrap;
  assign wrap = busy_q && baud_q == CNT_W'(BAUD_DIV - 1);
  assign tx_done = wrap && bit_q == 4'(FRAME_BITS - 1);
  assign TX = tx_q;
  assign tx_busy = busy_q;
  always_comb begin
    busy_d = trmt | (busy_q & ~tx_done);
    baud_d = (trmt | wrap | ~busy_q) ? '0 : baud_q + 1'b1;
    bit_d = (trmt | tx_done | ~busy_q) ? '0 : wrap ? bit_q + 1'b1 : bit_q;
    shift_d = trmt ? {1'b1, tx_data} : wrap ? {1'b1, shift_q[8:1]} : shift_q;
    tx_d = trmt ? 1'b0 : tx_done ? 1'b1 : wrap ? shift_q[0] : tx_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      busy_q <= busy_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
endmodule

// File: rtl/cmd_sender.sv
// cmd_sender: sends a 16-bit command as two back-to-back 8N1 bytes, high byte first
module cmd_sender
  import cmd_sender_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_9600_50M,
  parameter int CNT_W = 13
) (
  input logic clk,
  input logic rst_n,
  cmd_sender_if.slave bus
);
  snd_state_t state_q, state_d;
  logic [7:0] lo_q, lo_d;
  logic snt_q, snt_d;
  logic accept, trmt, tx_done, tx_busy;
  logic [7:0] tx_data;
  assign accept = bus.snd_cmd && state_q == IDLE && !tx_busy;
  assign trmt = accept | (state_q == HIGH && tx_done);
  assign tx_data = accept ? bus.cmd[15:8] : lo_q;
  assign bus.busy = state_q != IDLE;
  assign bus.cmd_snt = snt_q;
  always_comb begin
    state_d = state_q == IDLE ? (accept ? HIGH : IDLE) :
              state_q == HIGH ? (tx_done ? LOW : HIGH) :
              state_q == LOW  ? (tx_done ? IDLE : LOW) : IDLE;
    lo_d = accept ? bus.cmd[7:0] : lo_q;
    snt_d = accept ? 1'b0 : (state_q == LOW && tx_done) ? 1'b1 : snt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q <= '0;
      snt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      snt_q <= snt_d;
    end
  uart_tx_byte #(.BAUD_DIV(BAUD_DIV), .CNT_W(CNT_W)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .trmt(trmt),
    .tx_data(tx_data),
    .TX(bus.TX),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );
endmodule

// File: tb/tb_cmd_sender.sv
// tb_cmd_sender: directed checks of the two-byte command sender at BAUD_DIV=8
module tb_cmd_sender;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic tx_log [0:160];
  logic busy_log [0:160];
  logic snt_log [0:160];
  cmd_sender_if bus();
  cmd_sender #(.BAUD_DIV(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] dec(input int f);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = tx_log[f + (j + 1) * 8 + 4];
    return d;
  endfunction
  // index i of the logs holds cycle i+1 after acceptance; inj injects a request at that cycle
  task automatic capture(input int inj, input logic [15:0] ic);
    for (int i = 0; i < 161; i++) begin
      bus.snd_cmd = (i + 1 == inj);
      if (i + 1 == inj) bus.cmd = ic;
      tx_log[i] = bus.TX;
      busy_log[i] = bus.busy;
      snt_log[i] = bus.cmd_snt;
      @(negedge clk);
    end
    bus.snd_cmd = 1'b0;
  endtask
  task automatic send(input logic [15:0] c, input int inj = 0, input logic [15:0] ic = 16'h0);
    bus.cmd = c;
    bus.snd_cmd = 1'b1;
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    bus.cmd = ~c;
    capture(inj, ic);
  endtask
  initial begin
    int n;
    bus.cmd = 16'h0;
    bus.snd_cmd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.TX, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_snt", bus.cmd_snt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx", bus.TX, 1);
    send(16'h1234);
    chk("b_hi", dec(0), 8'h12);
    chk("b_lo", dec(80), 8'h34);
    chk("b_start_hi", tx_log[4], 0);
    chk("b_start_lo", tx_log[84], 0);
    chk("b_stop_hi", tx_log[76], 1);
    chk("b_stop_lo", tx_log[156], 1);
    n = 0;
    for (int i = 0; i < 161; i++) n += busy_log[i] ? 1 : 0;
    chk("b_busy_len", n, 160);
    chk("b_busy_last", busy_log[159], 1);
    chk("b_busy_fall", busy_log[160], 0);
    chk("b_snt_pre", snt_log[159], 0);
    chk("b_snt_rise", snt_log[160], 1);
    chk("b_snt_held", bus.cmd_snt, 1);
    send(16'h0001);
    chk("bb_snt_drop", snt_log[0], 0);
    chk("bb_start", tx_log[0], 0);
    chk("bb_hi", dec(0), 8'h00);
    chk("bb_lo", dec(80), 8'h01);
    chk("bb_snt_pre", snt_log[159], 0);
    chk("bb_snt_rise", snt_log[160], 1);
    repeat (5) @(negedge clk);
    send(16'hA5C3);
    chk("p_hi", dec(0), 8'hA5);
    chk("p_lo", dec(80), 8'hC3);
    chk("p_stop_hi", tx_log[76], 1);
    chk("p_stop_lo", tx_log[156], 1);
    chk("p_gap_end", tx_log[79], 1);
    chk("p_gap_start", tx_log[80], 0);
    repeat (5) @(negedge clk);
    send(16'h00F0, 40, 16'hFFFF);
    chk("ig_hi", dec(0), 8'h00);
    chk("ig_lo", dec(80), 8'hF0);
    n = 0;
    for (int i = 1; i < 161; i++) n += (snt_log[i] && !snt_log[i-1]) ? 1 : 0;
    chk("ig_snt_rises", n, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += (bus.TX && !bus.busy && bus.cmd_snt) ? 1 : 0;
      @(negedge clk);
    end
    chk("ig_idle_after", n, 20);
    send(16'h0000);
    n = 0;
    for (int i = 0; i < 72; i++) n += tx_log[i] ? 0 : 1;
    chk("z_low1", n, 72);
    n = 0;
    for (int i = 72; i < 80; i++) n += tx_log[i] ? 1 : 0;
    chk("z_stop1", n, 8);
    n = 0;
    for (int i = 80; i < 152; i++) n += tx_log[i] ? 0 : 1;
    chk("z_low2", n, 72);
    n = 0;
    for (int i = 152; i < 161; i++) n += tx_log[i] ? 1 : 0;
    chk("z_high_end", n, 9);
    repeat (3) @(negedge clk);
    bus.cmd = 16'h5555;
    bus.snd_cmd = 1'b1;
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    repeat (69) @(negedge clk);
    chk("r_tx_pre", bus.TX, 0);
    chk("r_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_tx", bus.TX, 1);
    chk("r_busy", bus.busy, 0);
    chk("r_snt", bus.cmd_snt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n += (bus.TX && !bus.busy) ? 1 : 0;
    end
    chk("r_quiet", n, 30);
    send(16'h1234);
    chk("r_resend_hi", dec(0), 8'h12);
    chk("r_resend_lo", dec(80), 8'h34);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_sender.md
Name: cmd_sender

Overview:
- Transmit-side counterpart of the command receiver: takes a 16-bit follower command and sends it over a UART TX line as two 8N1 bytes, high byte first.
- The receive-side wrapper reassembles those two bytes into the 16-bit cmd / cmd_rdy pair.
- Used in the remote/host-side controller and as the stimulus driver in full-chip benches.
- Contains the byte serializer and a two-byte sequencing FSM, with a sticky completion flag.

Parameters:
- BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600 baud); minimum legal value 2.
- CNT_W, 13, width of the baud counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset: asynchronous, active-low
- cmd  input  16  command word; sampled only when snd_cmd is accepted
- snd_cmd  input  1  single-cycle request to send cmd
- TX  output  1  serial line; idles high
- busy  output  1  high from acceptance until the low byte's stop bit completes
- cmd_snt  output  1  sticky; set when the full 16-bit command has left the line

Behaviour:
- Reset values: TX=1, busy=0, cmd_snt=0, FSM=IDLE, shift/count registers=0. Reset mid-frame aborts immediately; TX returns high asynchronously and no partial byte resumes after release.
- Acceptance:
  - snd_cmd is accepted only in IDLE.
  - On acceptance, cmd[7:0] is latched into a holding register and cmd[15:8] is loaded into the serializer.
  - snd_cmd while busy is ignored; the latched word is unchanged and no error is flagged.
- FSM states:
  - IDLE -> HIGH on accepted snd_cmd.
  - HIGH -> LOW when the serializer's tx_done pulses; the low byte loads the same cycle.
  - LOW -> IDLE when tx_done pulses; cmd_snt is set the same cycle.
- Serializer frame:
  - Start bit 0, then data bits [0]..[7] (LSB first), then stop bit 1; 10 bits total, each held exactly BAUD_DIV clocks.
  - TX is registered. The start bit appears the cycle after acceptance, i.e. TX low from cycle 1 when snd_cmd is high in cycle 0.
- Byte gap: the low byte's start bit follows the high byte's stop bit period with zero idle cycles.
- Latency: total frame is 20*BAUD_DIV clocks from the first TX-low cycle. busy falls and cmd_snt rises on the cycle after the last stop-bit clock.
- busy: asserted from the cycle after acceptance through the end of the LOW stop bit; low in IDLE.
- cmd_snt: cleared on an accepted snd_cmd; set at LOW->IDLE; otherwise held. If a set event and an acceptance fall in the same cycle, the clear wins. This cannot occur in a correct FSM but must be coded with that priority.
- Counters:
  - The baud counter counts 0..BAUD_DIV-1 and wraps. A bit shift occurs on the wrap.
  - The bit counter counts 0..9; tx_done pulses for 1 cycle when bit 9 (stop) finishes.
  - No counter wraps silently outside a frame; both are held at 0 when idle.
- cmd may change freely after acceptance with no effect on the frame in flight.

Decomposition:
- Package cmd_sender_pkg:
  - typedef enum logic [1:0] {IDLE, HIGH, LOW} snd_state_t
  - localparam FRAME_BITS = 10
  - localparam BAUD_DIV_9600_50M = 5208
- Sub-module uart_tx_byte (clk, rst_n, trmt, tx_data[7:0], TX, tx_busy, tx_done) holds the baud counter, bit counter and the 9-bit shift register. cmd_sender instantiates one copy and owns the FSM, the low-byte holding register and cmd_snt.

Test Plan:
- Use BAUD_DIV=8 throughout.
- Basic send: snd_cmd with cmd=16'h1234 -> TX carries 0x12 then 0x34 in 8N1, LSB first. Each bit lasts 8 clocks. busy is high for 160 clocks. cmd_snt rises at clock 161 after acceptance.
- Bit pattern: cmd=16'hA5C3 -> a bench-side receiver sampling mid-bit decodes 0xA5 then 0xC3. Both stop bits are 1 and there are 0 idle clocks between the bytes.
- Busy ignore: second snd_cmd with cmd=16'hFFFF at clock 40 of a 16'h00F0 send -> decoded bytes are still 0x00, 0xF0, and only one cmd_snt set.
- Back-to-back: snd_cmd on the cycle after cmd_snt rises, cmd=16'h0001 -> cmd_snt drops the next cycle, the new start bit begins, and cmd_snt re-rises 160 clocks later.
- Reset mid-frame: assert rst_n low at clock 70 of a 16'h5555 send -> TX=1, busy=0, cmd_snt=0 immediately. After release TX stays high until the next snd_cmd.
- Stop-bit integrity: cmd=16'h0000 -> TX is low for 9 bit-times (72 clocks), high for exactly 8, low for 72, high thereafter.
